timed_step_sequencer: RTL

//  Initiator side of the seconds-timer handshake (start/delay/done).

---
 rtl/toybox_seq_pkg.sv | 20 ++
 rtl/seq_prog_mem.sv | 37 +++
 rtl/timed_step_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/toybox_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : toybox_seq_pkg
//  Description : Shared state encoding and default widths for the step sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package toybox_seq_pkg;

    localparam int C_DLY_W = 8;
    localparam int C_ACT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : seq_prog_mem
//  Description : Program table, synchronous write / asynchronous read, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_prog_mem
    import toybox_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ACT_W  = C_ACT_W,
    parameter int DLY_W  = C_DLY_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ACT_W-1:0]  wr_action,
    input  logic [DLY_W-1:0]  wr_delay,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACT_W-1:0]  rd_action,
    output logic [DLY_W-1:0]  rd_delay
);

    logic [ACT_W+DLY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_action, wr_delay};
        end
    end

    // Same-cycle write and read return the old entry; the write lands at the edge.
    assign {rd_action, rd_delay} = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/timed_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : timed_step_sequencer
//  Description : Steps through {action, delay} entries, driving a seconds timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module timed_step_sequencer
    import toybox_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ACT_W  = C_ACT_W,
    parameter int DLY_W  = C_DLY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ACT_W-1:0]  wr_action,
    input  logic [DLY_W-1:0]  wr_delay,
    input  logic [ADDR_W:0]   num_steps,
    input  logic              loop_en,
    input  logic              go,
    input  logic              abort,
    input  logic              timer_done,
    output logic              timer_start,
    output logic [DLY_W-1:0]  timer_delay,
    output logic [ACT_W-1:0]  action,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              finished
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_num;
    logic              r_loop;
    logic              r_timer_start;
    logic [DLY_W-1:0]  r_timer_delay;
    logic [ACT_W-1:0]  r_action;
    logic              r_finished;

    logic [ACT_W-1:0]  w_rd_action;
    logic [DLY_W-1:0]  w_rd_delay;
    logic [ADDR_W:0]   w_num_sat;
    logic [ADDR_W:0]   w_idx_next;
    logic              w_more;

    seq_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .ACT_W  (ACT_W),
        .DLY_W  (DLY_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_action (wr_action),
        .wr_delay  (wr_delay),
        .rd_addr   (r_idx),
        .rd_action (w_rd_action),
        .rd_delay  (w_rd_delay)
    );

    assign w_num_sat  = (num_steps > C_DEPTH) ? C_DEPTH : num_steps;
    assign w_idx_next = {1'b0, r_idx} + 1'b1;
    assign w_more     = (w_idx_next < r_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_num         <= '0;
            r_loop        <= 1'b0;
            r_timer_start <= 1'b0;
            r_timer_delay <= '0;
            r_action      <= '0;
            r_finished    <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            if (abort) begin
                r_state       <= IDLE;
                r_timer_start <= 1'b0;
                r_action      <= '0;
                r_idx         <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (go) begin
                            r_num   <= w_num_sat;
                            r_loop  <= loop_en;
                            r_idx   <= '0;
                            r_state <= LOAD;
                        end
                    end
                    LOAD: begin
                        // An empty program completes without ever touching the timer.
                        if (r_num == '0) begin
                            r_state    <= IDLE;
                            r_finished <= 1'b1;
                        end else begin
                            r_action      <= w_rd_action;
                            r_timer_delay <= w_rd_delay;
                            r_timer_start <= 1'b1;
                            r_state       <= RUN;
                        end
                    end
                    RUN: begin
                        if (timer_done) begin
                            r_timer_start <= 1'b0;
                            r_state       <= GAP;
                        end
                    end
                    GAP: begin
                        if (w_more) begin
                            r_idx   <= w_idx_next[ADDR_W-1:0];
                            r_state <= LOAD;
                        end else if (r_loop) begin
                            r_idx   <= '0;
                            r_state <= LOAD;
                        end else begin
                            r_state    <= IDLE;
                            r_finished <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign timer_start = r_timer_start;
    assign timer_delay = r_timer_delay;
    assign action      = r_action;
    assign step_idx    = r_idx;
    assign busy        = (r_state != IDLE);
    assign finished    = r_finished;

endmodule
`default_nettype wire
